cpu_phase_seq: RTL and testbench
================================

CPU_PHASE_SEQ -- requirements
Module: cpu_phase_seq

Interface
REQ-001 SHALL have parameter IF_CYCLES, default 2, instruction-fetch latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum cycles spent waiting for mem_ready; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have run  input  1  level; high permits instruction sequencing.
REQ-007 SHALL have is_mem  input  1  current instruction is a load or store (MemRead|MemWrite); sampled in EX.
REQ-008 SHALL have mem_ready  input  1  data-memory completion handshake; sampled only in MEM.
REQ-009 SHALL have halt_req  input  1  level; debug halt request taken at an instruction boundary.
REQ-010 SHALL have step  input  1  single-step pulse; present only when SINGLE_STEP_EN is defined.
REQ-011 SHALL have if_en, id_en, ex_en, mem_en, wb_en  output  1 each  one-hot phase enables.
REQ-012 SHALL have pc_en  output  1  one-cycle PC-update pulse.
REQ-013 SHALL have phase  output  3  encoded state: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
REQ-014 SHALL have busy  output  1  high in IF, ID, EX, MEM and WB.
REQ-015 SHALL have mem_err  output  1  sticky memory-timeout flag.
REQ-016 SHALL have instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-017 IDLE: all enables low; SHALL move to IF on the next edge when run=1.
REQ-018 IF: if_en SHALL be high for exactly IF_CYCLES consecutive cycles, then ID.
REQ-019 ID and EX: one cycle each; id_en/ex_en high for that cycle.
REQ-020 EX SHALL go to MEM if is_mem=1, otherwise to WB.
REQ-021 MEM: mem_en high every cycle; SHALL go to WB on the edge ending the first cycle with mem_ready=1.
REQ-022 MEM: if mem_ready has not been seen after MEM_TIMEOUT cycles, SHALL set mem_err and go to WB; mem_err clears only on rst.
REQ-023 WB: wb_en and pc_en SHALL be high for one cycle; instr_cnt SHALL increment by 1 and wrap from 2^CNT_W-1 to 0.
REQ-024 WB next-state priority SHALL be: halt_req=1 -> HALT; else run=0 -> IDLE; else IF.
REQ-025 HALT: all enables low; when halt_req=0, SHALL go to IF if run=1, else IDLE.
REQ-026 Latency SHALL be IF_CYCLES+3 cycles per non-memory instruction and IF_CYCLES+3+k per memory instruction, where k is the MEM cycle count (1..MEM_TIMEOUT).
REQ-027 Deasserting run or asserting halt_req mid-instruction SHALL NOT abort it; it takes effect only at WB.
REQ-028 mem_ready outside MEM and is_mem outside EX SHALL be ignored.
REQ-029 Exactly one of if_en..wb_en SHALL be high in IF..WB; none in IDLE or HALT.

Reset
REQ-030 On rst=1 at an edge: state IDLE, IF and MEM counters 0, all enables and pc_en 0, busy 0, mem_err 0, instr_cnt 0, phase 0.
REQ-031 rst asserted mid-instruction SHALL suppress pc_en and the instr_cnt increment for that instruction.

Configuration
REQ-032 Macro SINGLE_STEP_EN defined: step port SHALL exist; in HALT with halt_req=1, a step=1 cycle SHALL execute exactly one instruction (IF..WB), then return to HALT.
REQ-033 Macro SINGLE_STEP_EN undefined: step port SHALL be absent; HALT SHALL exit only when halt_req=0.

Verification
REQ-034 IF_CYCLES=2, rst then run=1, is_mem=0 -> phase 0,1,1,2,3,5,1...; pc_en every 5th cycle; instr_cnt=3 after 15 cycles in IF..WB.
REQ-035 is_mem=1, mem_ready high on 3rd MEM cycle -> 3 MEM cycles, pc_en 8 cycles after leaving IDLE, mem_err=0.
REQ-036 MEM_TIMEOUT=4, is_mem=1, mem_ready=0 -> 4 MEM cycles, then WB, mem_err=1 and held until rst.
REQ-037 halt_req=1 raised during ID -> instruction completes, phase=6 after WB; halt_req=0 with run=1 -> IF next cycle.
REQ-038 CNT_W=4, 16 non-memory instructions -> instr_cnt wraps 15->0; rst asserted during EX -> phase=0, no pc_en.
REQ-039 SINGLE_STEP_EN defined, in HALT, step pulse -> exactly one pc_en, instr_cnt+1, back to HALT.

Source files
------------

// File: rtl/cpu_phase_seq_if.sv
// Handshake/status bundle for cpu_phase_seq. The step wire exists only when
// SINGLE_STEP_EN is defined.
interface cpu_phase_seq_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             is_mem;
  logic             mem_ready;
  logic             halt_req;
`ifdef SINGLE_STEP_EN
  logic             step;
`endif
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             mem_en;
  logic             wb_en;
  logic             pc_en;
  logic [2:0]       phase;
  logic             busy;
  logic             mem_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output run, is_mem, mem_ready, halt_req,
    input  if_en, id_en, ex_en, mem_en, wb_en, pc_en,
    input  phase, busy, mem_err, instr_cnt
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  run, is_mem, mem_ready, halt_req,
    output if_en, id_en, ex_en, mem_en, wb_en, pc_en,
    output phase, busy, mem_err, instr_cnt
  );
endinterface

// File: rtl/cpu_phase_seq.sv
// Multi-cycle CPU phase sequencer: IDLE -> IF (xIF_CYCLES) -> ID -> EX -> [MEM] -> WB.
// Optional feature: define SINGLE_STEP_EN to add the step port (single-step out of HALT).
module cpu_phase_seq #(
  parameter int IF_CYCLES   = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  cpu_phase_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [3:0] IF_LAST  = 4'(IF_CYCLES - 1);
  localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       if_cnt_q;
  logic [7:0]       mem_cnt_q;
  logic             err_q;
  logic             err_set;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;
  logic             step_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      if_cnt_q  <= '0;
      mem_cnt_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      if_cnt_q  <= (state_q == S_IF  && state_d == S_IF)  ? if_cnt_q + 4'd1  : '0;
      mem_cnt_q <= (state_q == S_MEM && state_d == S_MEM) ? mem_cnt_q + 8'd1 : '0;
      if (err_set)
        err_q <= 1'b1;
      // Retire on the edge that ends WB; a reset during WB wins and drops it.
      if (state_q == S_WB)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SINGLE_STEP_EN
  // Remembers that the current instruction was launched by a step pulse,
  // so WB returns to HALT regardless of halt_req.
  always_ff @(posedge clk) begin
    if (rst)
      step_q <= 1'b0;
    else if (step_set)
      step_q <= 1'b1;
    else if (state_q == S_WB)
      step_q <= 1'b0;
  end
`else
  assign step_q = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    step_set = 1'b0;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_IF;
      S_IF:   if (if_cnt_q == IF_LAST) state_d = S_ID;
      S_ID:   state_d = S_EX;
      S_EX:   state_d = bus.is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = S_WB;
        end else if (mem_cnt_q == MEM_LAST) begin
          state_d = S_WB;
          err_set = 1'b1;
        end
      end
      S_WB: begin
        if (step_q || bus.halt_req) state_d = S_HALT;
        else if (!bus.run)          state_d = S_IDLE;
        else                        state_d = S_IF;
      end
      S_HALT: begin
        if (!bus.halt_req) begin
          state_d = bus.run ? S_IF : S_IDLE;
        end
`ifdef SINGLE_STEP_EN
        else if (bus.step) begin
          state_d  = S_IF;
          step_set = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.if_en  = 1'b0;
    bus.id_en  = 1'b0;
    bus.ex_en  = 1'b0;
    bus.mem_en = 1'b0;
    bus.wb_en  = 1'b0;
    bus.pc_en  = 1'b0;
    bus.busy   = 1'b0;
    case (state_q)
      S_IF:  begin bus.if_en  = 1'b1; bus.busy = 1'b1; end
      S_ID:  begin bus.id_en  = 1'b1; bus.busy = 1'b1; end
      S_EX:  begin bus.ex_en  = 1'b1; bus.busy = 1'b1; end
      S_MEM: begin bus.mem_en = 1'b1; bus.busy = 1'b1; end
      S_WB:  begin bus.wb_en  = 1'b1; bus.pc_en = 1'b1; bus.busy = 1'b1; end
      default: ;
    endcase
  end

  assign bus.phase     = state_q;
  assign bus.mem_err   = err_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Directed bench for cpu_phase_seq: expected per-cycle results are queued
// before each edge and popped/compared after it.
module tb_cpu_phase_seq;
  localparam int IFC = 2;
  localparam int MTO = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_phase_seq_if #(.CNT_W(CW)) bus();

  cpu_phase_seq #(.IF_CYCLES(IFC), .MEM_TIMEOUT(MTO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [2:0]    ph;
    logic          pc;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int halt_tick = -1;
  int run_off_tick = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] en_of(input logic [2:0] ph);
    case (ph)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01000;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00010;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic tick(input logic [2:0] ph, input logic pc, input logic [CW-1:0] cnt, input logic err);
    exp_t e, g;
    e.ph = ph; e.pc = pc; e.cnt = cnt; e.err = err;
    q.push_back(e);
    @(posedge clk); #1;
    g = q.pop_front();
    chk("phase",     32'(bus.phase),     32'(g.ph));
    chk("pc_en",     32'(bus.pc_en),     32'(g.pc));
    chk("instr_cnt", 32'(bus.instr_cnt), 32'(g.cnt));
    chk("mem_err",   32'(bus.mem_err),   32'(g.err));
    chk("enables",   32'({bus.if_en, bus.id_en, bus.ex_en, bus.mem_en, bus.wb_en}), 32'(en_of(g.ph)));
    chk("busy",      32'(bus.busy),      32'(g.ph >= 3'd1 && g.ph <= 3'd5));
  endtask

  task automatic hook(input int t);
    if (t == halt_tick)    bus.halt_req = 1'b1;
    if (t == run_off_tick) bus.run = 1'b0;
`ifdef SINGLE_STEP_EN
    if (t == 0) bus.step = 1'b0;
`endif
  endtask

  // One instruction from the edge entering IF through WB. Misleading is_mem and
  // mem_ready values are driven outside EX/MEM to show they are ignored.
  task automatic do_instr(input bit mem, input int rdy_at, input logic [CW-1:0] cnt0, input logic err0);
    int t;
    int n;
    logic err1;
    t = 0;
    bus.is_mem = !mem;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < IFC; i++) begin
      tick(3'd1, 1'b0, cnt0, err0); hook(t); t++;
    end
    tick(3'd2, 1'b0, cnt0, err0); hook(t); t++;
    tick(3'd3, 1'b0, cnt0, err0); hook(t); t++;
    bus.is_mem = mem;
    bus.mem_ready = 1'b0;
    err1 = err0 | (mem && rdy_at == 0);
    if (mem) begin
      n = (rdy_at > 0) ? rdy_at : MTO;
      for (int k = 1; k <= n; k++) begin
        tick(3'd4, 1'b0, cnt0, err0); hook(t); t++;
        bus.mem_ready = (k == rdy_at);
      end
    end
    tick(3'd5, 1'b1, cnt0, err1);
    bus.mem_ready = 1'b0;
    bus.is_mem = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b0;
    bus.is_mem = 1'b0;
    bus.mem_ready = 1'b0;
    bus.halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    // Reset state, then idle with run low
    tick(3'd0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    tick(3'd0, 1'b0, 4'd0, 1'b0);

    // Back-to-back non-memory instructions: 1,1,2,3,5 pattern
    bus.run = 1'b1;
    do_instr(1'b0, 0, 4'd0, 1'b0);
    do_instr(1'b0, 0, 4'd1, 1'b0);
    do_instr(1'b0, 0, 4'd2, 1'b0);

    // Memory: ready on 3rd MEM cycle, ready on the last allowed cycle, timeout
    do_instr(1'b1, 3,   4'd3, 1'b0);
    do_instr(1'b1, MTO, 4'd4, 1'b0);
    do_instr(1'b1, 0,   4'd5, 1'b0);
    do_instr(1'b0, 0,   4'd6, 1'b1);

    // run dropped in IF and halt raised in ID: instruction completes, then HALT
    halt_tick = IFC;
    run_off_tick = 0;
    do_instr(1'b0, 0, 4'd7, 1'b1);
    halt_tick = -1;
    run_off_tick = -1;
    tick(3'd6, 1'b0, 4'd8, 1'b1);
    bus.run = 1'b1;
    tick(3'd6, 1'b0, 4'd8, 1'b1);
    bus.halt_req = 1'b0;
    do_instr(1'b0, 0, 4'd8, 1'b1);

    // Counter wrap 15 -> 0
    for (int c = 9; c <= 15; c++)
      do_instr(1'b0, 0, 4'(c), 1'b1);
    do_instr(1'b0, 0, 4'd0, 1'b1);
    bus.run = 1'b0;
    tick(3'd0, 1'b0, 4'd1, 1'b1);
    tick(3'd0, 1'b0, 4'd1, 1'b1);

    // Reset during EX: back to IDLE, no pc_en, flags cleared
    bus.run = 1'b1;
    tick(3'd1, 1'b0, 4'd1, 1'b1);
    tick(3'd1, 1'b0, 4'd1, 1'b1);
    tick(3'd2, 1'b0, 4'd1, 1'b1);
    tick(3'd3, 1'b0, 4'd1, 1'b1);
    rst = 1'b1;
    bus.run = 1'b0;
    tick(3'd0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    tick(3'd0, 1'b0, 4'd0, 1'b0);

`ifdef SINGLE_STEP_EN
    // Single step out of HALT while halt_req stays high
    bus.run = 1'b1;
    bus.halt_req = 1'b1;
    do_instr(1'b0, 0, 4'd0, 1'b0);
    tick(3'd6, 1'b0, 4'd1, 1'b0);
    bus.step = 1'b1;
    do_instr(1'b0, 0, 4'd1, 1'b0);
    tick(3'd6, 1'b0, 4'd2, 1'b0);
    tick(3'd6, 1'b0, 4'd2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
